// File: rtl/button_event_decoder.sv
`default_nettype none
// ============================================================================
// Module   : button_event_decoder
// Brief    : Turns a debounced button level into press/release edges and
//            single-click, double-click and long-press single-cycle events.
// Revision : 1.0 - initial release
// ============================================================================
module button_event_decoder #(
    parameter int LONG_CYCLES = 50000000,
    parameter int GAP_CYCLES  = 15000000,
    parameter int CNT_W       = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb_db,
    output logic press_pulse,
    output logic release_pulse,
    output logic single_click,
    output logic double_click,
    output logic long_press,
    output logic busy
);

    localparam logic [CNT_W-1:0] c_long_last = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_gap_last  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_one   = CNT_W'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_GAP    = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_LONG   = 3'd4
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_pb_prev;
    logic             w_rise;
    logic             w_fall;
    logic             w_single;
    logic             w_double;
    logic             w_long;

    assign w_rise = pb_db & ~r_pb_prev;
    assign w_fall = ~pb_db & r_pb_prev;

    // A press/release edge always takes priority over a timer expiring on the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_single    = 1'b0;
        w_double    = 1'b0;
        w_long      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_state_nxt = ST_PRESS1;
                    w_cnt_nxt   = '0;
                end
            end
            ST_PRESS1: begin
                if (w_fall) begin
                    w_state_nxt = ST_GAP;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_long_last) begin
                    w_state_nxt = ST_LONG;
                    w_long      = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + c_cnt_one;
                end
            end
            ST_GAP: begin
                if (w_rise) begin
                    w_state_nxt = ST_PRESS2;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_gap_last) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_single    = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt + c_cnt_one;
                end
            end
            ST_PRESS2: begin
                if (w_fall) begin
                    w_state_nxt = ST_IDLE;
                    w_double    = 1'b1;
                end
            end
            ST_LONG: begin
                if (w_fall) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state decode so they align with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_pb_prev     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            single_click  <= 1'b0;
            double_click  <= 1'b0;
            long_press    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_pb_prev     <= pb_db;
            press_pulse   <= w_rise;
            release_pulse <= w_fall;
            single_click  <= w_single;
            double_click  <= w_double;
            long_press    <= w_long;
            busy          <= (w_state_nxt != ST_IDLE);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_button_event_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_button_event_decoder
// Brief    : Directed and random button gestures against a timestamp model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_button_event_decoder;

    localparam int LONG_CYCLES = 8;
    localparam int GAP_CYCLES  = 6;
    localparam int CNT_W       = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic pb_db = 1'b0;
    logic press_pulse, release_pulse, single_click, double_click, long_press, busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a gesture is tracked by press/release timestamps.
    bit m_prev, m_active, m_held, m_long_done;
    int m_presses, m_t_press, m_t_rel, cyc;

    always #5 clk = ~clk;

    button_event_decoder #(
        .LONG_CYCLES (LONG_CYCLES),
        .GAP_CYCLES  (GAP_CYCLES),
        .CNT_W       (CNT_W)
    ) u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pb_db         (pb_db),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .single_click  (single_click),
        .double_click  (double_click),
        .long_press    (long_press),
        .busy          (busy)
    );

    function automatic logic [5:0] outs();
        return {press_pulse, release_pulse, single_click, double_click, long_press, busy};
    endfunction

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d: got {prs,rel,sgl,dbl,lng,busy}=%b expected %b", tag, cyc, got, exp);
        end
    endtask

    // Expected outputs visible after a clock edge that sampled level v.
    task automatic model_edge(input bit v, output logic [5:0] exp);
        bit rise, fall, e_single, e_double, e_long;
        e_single = 0; e_double = 0; e_long = 0;
        if (!rst_n) begin
            m_prev = 0; m_active = 0; m_held = 0; m_long_done = 0; m_presses = 0;
            exp = '0;
            return;
        end
        rise   = v & ~m_prev;
        fall   = ~v & m_prev;
        m_prev = v;
        if (!m_active) begin
            if (rise) begin
                m_active = 1; m_held = 1; m_presses = 1; m_t_press = cyc; m_long_done = 0;
            end
        end else if (m_held) begin
            if (fall) begin
                m_held  = 0;
                m_t_rel = cyc;
                if (m_presses == 2 || m_long_done) begin
                    e_double = (m_presses == 2);
                    m_active = 0;
                end
            end else if (m_presses == 1 && !m_long_done && (cyc - m_t_press) == LONG_CYCLES) begin
                e_long      = 1;
                m_long_done = 1;
            end
        end else begin
            if (rise) begin
                m_presses = 2; m_held = 1;
            end else if ((cyc - m_t_rel) == GAP_CYCLES) begin
                e_single = 1;
                m_active = 0;
            end
        end
        exp = {rise, fall, e_single, e_double, e_long, m_active};
    endtask

    task automatic step(input bit v, input string tag);
        logic [5:0] exp;
        pb_db = v;
        @(posedge clk);
        cyc++;
        model_edge(v, exp);
        #1;
        check(tag, outs(), exp);
    endtask

    task automatic hold(input bit v, input int n, input string tag);
        repeat (n) step(v, tag);
    endtask

    initial begin
        cyc = 0;
        rst_n = 1'b0;
        for (int i = 0; i < 6; i++) step(i[0], "reset_hold");
        rst_n = 1'b1;
        hold(0, 3, "idle");

        hold(1, 3, "single"); hold(0, 12, "single");
        hold(1, 2, "double"); hold(0, 3, "double");
        hold(1, 2, "double"); hold(0, 10, "double");
        hold(1, 20, "long");  hold(0, 10, "long");

        hold(1, 2, "gap6"); hold(0, GAP_CYCLES, "gap6");
        hold(1, 2, "gap6"); hold(0, 10, "gap6");
        hold(1, 2, "gap7"); hold(0, GAP_CYCLES + 1, "gap7");
        hold(1, 2, "gap7"); hold(0, 10, "gap7");

        // Reset in the middle of the gap, then release with the button held.
        hold(1, 2, "midrst"); hold(0, 3, "midrst");
        #2 rst_n = 1'b0;
        #1 check("async_rst", outs(), 6'b000000);
        step(1, "midrst_hold"); step(0, "midrst_hold"); step(1, "midrst_hold");
        rst_n = 1'b1;
        step(1, "rst_release_press");
        hold(1, 2, "post_rst"); hold(0, 10, "post_rst");

        for (int g = 0; g < 300; g++) begin
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                hold(1'($urandom_range(0, 1)), 2, "rand_rst");
                rst_n = 1'b1;
            end
            hold(1, $urandom_range(1, 12), "rand_hi");
            hold(0, $urandom_range(1, 10), "rand_lo");
        end
        hold(0, 12, "drain");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_event_decoder.md
Name: button_event_decoder

Overview:
- Sits directly downstream of the push-button debouncer and consumes its clean, synchronized level output.
- Classifies presses into single-cycle events for the mic-array control logic: press edge, release edge, single click, double click and long press.
- Lets one physical button drive record start/stop and mode-select without any software timing.

Parameters:
- LONG_CYCLES, 50000000, hold time that qualifies a long press (1 s at 50 MHz); must be >= 2
- GAP_CYCLES, 15000000, maximum release-to-press gap for a double click (0.3 s at 50 MHz); must be >= 2
- CNT_W, 26, counter width; must satisfy 2^CNT_W > max(LONG_CYCLES, GAP_CYCLES)

Ports:
- clk  in  1  system clock, 50 MHz
- rst_n  in  1  asynchronous active-low reset
- pb_db  in  1  debounced, synchronized button level; 1 = pressed
- press_pulse  out  1  one-cycle pulse on each 0->1 of pb_db
- release_pulse  out  1  one-cycle pulse on each 1->0 of pb_db
- single_click  out  1  one-cycle pulse: short press not followed by a second press within the gap
- double_click  out  1  one-cycle pulse: two short presses within the gap
- long_press  out  1  one-cycle pulse: press held LONG_CYCLES
- busy  out  1  1 whenever the FSM is not in IDLE

Behaviour:
- Clock and reset
  - Single clock domain. Every output is registered. No combinational path from pb_db to any output.
  - rst_n low asynchronously clears state to IDLE, the counter to 0, pb_prev to 0 and all outputs to 0.
  - Reset mid-gesture discards that gesture; no event is emitted for it.
- Edge detection
  - pb_prev registers pb_db. rise = pb_db & ~pb_prev; fall = ~pb_db & pb_prev.
  - Let edge e be the clock edge at which rise (or fall) is true. press_pulse (release_pulse) is high for exactly the cycle after edge e.
  - If pb_db is already high at reset release, pb_prev = 0 causes a rise, which is treated as a normal press.
- FSM states: IDLE, PRESS1, GAP, PRESS2, LONG.
  - IDLE: rise -> PRESS1, cnt <= 0.
  - PRESS1: fall -> GAP, cnt <= 0. Else, if cnt == LONG_CYCLES-1 -> LONG and long_press pulses. Else cnt++.
    - long_press therefore rises exactly LONG_CYCLES cycles after press_pulse.
  - GAP: rise -> PRESS2. Else, if cnt == GAP_CYCLES-1 -> IDLE and single_click pulses. Else cnt++.
    - single_click therefore rises exactly GAP_CYCLES cycles after release_pulse.
    - If rise and expiry occur on the same edge, rise wins: go to PRESS2, no single_click.
  - PRESS2: fall -> IDLE, and double_click pulses in the same cycle as release_pulse. No long-press timing in this state.
  - LONG: fall -> IDLE. No click event is emitted.
- Pulse and counter rules
  - Pulse outputs default to 0 every cycle; each event is exactly 1 cycle wide.
  - At most one of single_click, double_click, long_press is high in any cycle.
  - press_pulse/release_pulse may coincide with double_click, but never with single_click or long_press.
  - cnt never wraps: it is reset or stopped before reaching max(LONG_CYCLES, GAP_CYCLES).
- busy = (state != IDLE), registered, so it updates alongside the state register.

Test Plan (override LONG_CYCLES=8, GAP_CYCLES=6, CNT_W=4):
- Reset: hold rst_n=0 with pb_db toggling -> all outputs stay 0. Release rst_n with pb_db=0 -> busy=0, no pulses.
- Single click: pb_db high 3 cycles, then low 12 -> press_pulse 1 cycle; release_pulse 3 cycles later; single_click exactly 6 cycles after release_pulse; busy then 0; no double_click or long_press.
- Double click: high 2, low 3, high 2, low -> two press_pulses; double_click in the same cycle as the second release_pulse; no single_click.
- Long press: high 20 cycles -> long_press exactly 8 cycles after press_pulse, once only; release gives release_pulse only; no click events.
- Gap boundary: second rise sampled exactly 6 edges after the first fall -> double_click, no single_click. Second rise at 7 edges -> single_click at 6, then a fresh PRESS1.
- Mid-gesture reset: assert rst_n during GAP -> outputs cleared immediately; no single_click emitted; with pb_db high at reset release -> press_pulse on the first cycle.
